// File: rtl/pwm_capture.sv
// PWM high-time / period capture: synchronizes an asynchronous PWM input,
// measures rise-to-fall and rise-to-rise spacing in clk cycles, flags stalls.
module pwm_capture #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cycles,
    output logic [CNT_W-1:0] period_cycles,
    output logic             meas_valid,
    output logic             timeout,
    output logic             level
);

    localparam int unsigned     FILL_W    = 3;
    localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]       high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0]       idle_inc;
    logic [CNT_W-1:0]       high_cycles_q, high_cycles_d;
    logic [CNT_W-1:0]       period_cycles_q, period_cycles_d;
    logic                   meas_valid_q, meas_valid_d;
    logic                   timeout_q, timeout_d;
    logic                   sync_level;
    logic                   edge_en;
    logic                   rise;
    logic                   fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Synchronizer and edge detect; edges are masked until both the chain and
    // the edge register hold real samples, so a line already high at reset
    // release is not mistaken for a rise.
    always_comb begin
        sync_level = sync_q[SYNC_STAGES-1];
        sync_d     = {sync_q[SYNC_STAGES-2:0], pwm_in};
        prev_d     = sync_level;
        fill_d     = (fill_q == FILL_DONE) ? fill_q : fill_q + FILL_W'(1);
        edge_en    = (fill_q == FILL_DONE);
        rise       = edge_en & sync_level & ~prev_q;
        fall       = edge_en & ~sync_level & prev_q;
    end

    // Measurement FSM; a rise always wins over a saturating counter.
    always_comb begin
        state_d         = state_q;
        per_cnt_d       = per_cnt_q;
        high_cnt_d      = high_cnt_q;
        hold_d          = hold_q;
        idle_cnt_d      = idle_cnt_q;
        high_cycles_d   = high_cycles_q;
        period_cycles_d = period_cycles_q;
        meas_valid_d    = 1'b0;
        timeout_d       = 1'b0;
        idle_inc        = idle_cnt_q + CNT_ONE;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = HIGH;
                    per_cnt_d  = CNT_ONE;
                    high_cnt_d = CNT_ONE;
                    idle_cnt_d = '0;
                end else if (idle_inc == CNT_MAX) begin
                    timeout_d  = 1'b1;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_inc;
                end
            end
            HIGH: begin
                if (rise) begin
                    period_cycles_d = per_cnt_q;
                    high_cycles_d   = high_cnt_q;
                    hold_d          = high_cnt_q;
                    meas_valid_d    = 1'b1;
                    per_cnt_d       = CNT_ONE;
                    high_cnt_d      = CNT_ONE;
                end else if (per_cnt_q == CNT_MAX) begin
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end else begin
                    per_cnt_d  = sat_inc(per_cnt_q);
                    high_cnt_d = sat_inc(high_cnt_q);
                    if (fall) begin
                        state_d = LOW;
                        hold_d  = high_cnt_q;
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_d         = HIGH;
                    period_cycles_d = per_cnt_q;
                    high_cycles_d   = hold_q;
                    meas_valid_d    = 1'b1;
                    per_cnt_d       = CNT_ONE;
                    high_cnt_d      = CNT_ONE;
                end else if (per_cnt_q == CNT_MAX) begin
                    timeout_d  = 1'b1;
                    state_d    = IDLE;
                    idle_cnt_d = '0;
                end else begin
                    per_cnt_d = sat_inc(per_cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q          <= '0;
            prev_q          <= 1'b0;
            fill_q          <= '0;
            state_q         <= IDLE;
            per_cnt_q       <= '0;
            high_cnt_q      <= '0;
            hold_q          <= '0;
            idle_cnt_q      <= '0;
            high_cycles_q   <= '0;
            period_cycles_q <= '0;
            meas_valid_q    <= 1'b0;
            timeout_q       <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            prev_q          <= prev_d;
            fill_q          <= fill_d;
            state_q         <= state_d;
            per_cnt_q       <= per_cnt_d;
            high_cnt_q      <= high_cnt_d;
            hold_q          <= hold_d;
            idle_cnt_q      <= idle_cnt_d;
            high_cycles_q   <= high_cycles_d;
            period_cycles_q <= period_cycles_d;
            meas_valid_q    <= meas_valid_d;
            timeout_q       <= timeout_d;
        end
    end

    assign high_cycles   = high_cycles_q;
    assign period_cycles = period_cycles_q;
    assign meas_valid    = meas_valid_q;
    assign timeout       = timeout_q;
    assign level         = sync_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: a rise/fall timeline model predicts each
// published measurement and the number of stall timeouts.
module tb_pwm_capture;

    localparam int unsigned CNT_W       = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          MAXV        = (1 << CNT_W) - 1;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] period_cycles;
    logic             meas_valid;
    logic             timeout;
    logic             level;

    pwm_capture #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .high_cycles  (high_cycles),
        .period_cycles(period_cycles),
        .meas_valid   (meas_valid),
        .timeout      (timeout),
        .level        (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: timeline of driven edges, in clk cycles
    bit armed    = 1'b0;
    bit jitter   = 1'b0;
    int last_rise = 0;
    int last_fall = 0;
    int exp_high[$];
    int exp_per[$];
    int tmo_exp  = 0;
    int tmo_seen = 0;
    int mv_seen  = 0;
    int out_high = 0;
    int out_per  = 0;
    int tmo_times[$];
    int mon_h, mon_p, mon_d;

    function automatic void model_rise(input int t);
        int g;
        if (armed) begin
            g = t - last_rise;
            if (g <= MAXV) begin
                exp_high.push_back(last_fall - last_rise);
                exp_per.push_back(g);
                out_high = last_fall - last_rise;
                out_per  = g;
            end else begin
                tmo_exp += (g - 1) / MAXV;
            end
        end
        armed     = 1'b1;
        last_rise = t;
    endfunction

    function automatic void model_reset();
        armed = 1'b0;
        exp_high.delete();
        exp_per.delete();
        out_high = 0;
        out_per  = 0;
    endfunction

    always @(negedge clk) begin
        if (meas_valid) begin
            mv_seen++;
            check_val("meas_with_timeout", longint'(timeout), 0);
            if (exp_per.size() == 0) begin
                check_val("unexpected_meas", 1, 0);
            end else begin
                mon_h = exp_high.pop_front();
                mon_p = exp_per.pop_front();
                if (jitter) begin
                    mon_d = int'(high_cycles) - mon_h;
                    check_val("high_tol", longint'(mon_d >= -1 && mon_d <= 1), 1);
                    mon_d = int'(period_cycles) - mon_p;
                    check_val("period_tol", longint'(mon_d >= -1 && mon_d <= 1), 1);
                end else begin
                    check_val("high_cycles", longint'(high_cycles), mon_h);
                    check_val("period_cycles", longint'(period_cycles), mon_p);
                end
            end
        end
        if (timeout) begin
            tmo_seen++;
            tmo_times.push_back(cyc);
        end
    end

    // Hold pwm_in at v for n cycles; change lands ph time units after a clk edge
    task automatic seg(input bit v, input int n, input int ph);
        @(posedge clk);
        #(ph);
        if (v && !pwm_in) model_rise(cyc);
        if (!v && pwm_in) last_fall = cyc;
        pwm_in = v;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic do_reset(input bit pwm_level);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        pwm_in = pwm_level;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tmo_seen = 0;
        tmo_exp  = 0;
        mv_seen  = 0;
        tmo_times.delete();
    endtask

    task automatic end_phase(input string tag, input int ph);
        seg(1'b1, 12, ph);
        check_val({tag, "_pending"}, exp_per.size(), 0);
        check_val({tag, "_timeouts"}, tmo_seen, tmo_exp);
        if (!jitter) begin
            check_val({tag, "_out_high"}, longint'(high_cycles), out_high);
            check_val({tag, "_out_period"}, longint'(period_cycles), out_per);
        end
    endtask

    task automatic wave(input int h, input int l, input int reps, input int ph);
        for (int i = 0; i < reps; i++) begin
            seg(1'b1, h, ph);
            seg(1'b0, l, ph);
        end
    endtask

    initial begin
        int h, l, ph;

        // Reset with the line high: outputs clear, level forced low, no false rise
        do_reset(1'b1);
        check_val("rst_high_cycles", longint'(high_cycles), 0);
        check_val("rst_period_cycles", longint'(period_cycles), 0);
        check_val("rst_meas_valid", longint'(meas_valid), 0);
        check_val("rst_timeout", longint'(timeout), 0);
        check_val("rst_level", longint'(level), 0);
        repeat (10) @(posedge clk);
        #1;
        check_val("level_after_release", longint'(level), 1);
        seg(1'b0, 6, 1);
        wave(3, 5, 10, 1);
        end_phase("w3_5", 1);
        check_val("w3_5_high_const", longint'(high_cycles), 3);
        check_val("w3_5_period_const", longint'(period_cycles), 8);

        // Line held low after reset: periodic idle timeouts only
        do_reset(1'b0);
        repeat (3 * MAXV + 5) @(posedge clk);
        #1;
        check_val("idle_timeouts", tmo_seen, 3);
        check_val("idle_meas", mv_seen, 0);
        check_val("idle_level", longint'(level), 0);
        for (int i = 1; i < tmo_times.size(); i++)
            check_val("idle_spacing", tmo_times[i] - tmo_times[i-1], MAXV);

        // Fastest legal waveform
        do_reset(1'b0);
        seg(1'b0, 6, 1);
        wave(1, 1, 20, 1);
        end_phase("w1_1", 1);

        // Saturation boundary: 255 is measured, 256 times out
        do_reset(1'b0);
        seg(1'b0, 6, 1);
        wave(5, 250, 2, 1);
        wave(5, 251, 1, 1);
        wave(5, 10, 1, 1);
        end_phase("boundary", 1);

        // Stuck high after a 4/4 waveform, then resume
        do_reset(1'b0);
        seg(1'b0, 6, 1);
        wave(4, 4, 5, 1);
        seg(1'b1, 600, 1);
        check_val("stuck_high_hold", longint'(high_cycles), 4);
        check_val("stuck_period_hold", longint'(period_cycles), 8);
        check_val("stuck_timeouts", tmo_seen, 2);
        seg(1'b0, 4, 1);
        wave(4, 4, 4, 1);
        end_phase("stuck", 1);

        // One-cycle reset in the middle of a high phase
        do_reset(1'b0);
        seg(1'b0, 6, 1);
        wave(3, 5, 4, 1);
        seg(1'b1, 1, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_val("midrst_high", longint'(high_cycles), 0);
        check_val("midrst_period", longint'(period_cycles), 0);
        check_val("midrst_valid", longint'(meas_valid), 0);
        seg(1'b0, 5, 1);
        wave(3, 5, 4, 1);
        end_phase("midrst", 1);

        // Random waveforms, occasionally with stalls past saturation
        for (int r = 0; r < 6; r++) begin
            do_reset(1'b0);
            seg(1'b0, 6, 1);
            for (int i = 0; i < 25; i++) begin
                h = int'($urandom_range(20, 1));
                l = ($urandom_range(9, 0) == 0) ? int'($urandom_range(280, 230))
                                                : int'($urandom_range(20, 1));
                seg(1'b1, h, 1);
                seg(1'b0, l, 1);
            end
            end_phase("random", 1);
        end

        // Duty sweep over period 8 with edges at a random phase against clk
        for (int d = 1; d <= 7; d++) begin
            do_reset(1'b0);
            jitter = 1'b1;
            ph = int'($urandom_range(9, 1));
            seg(1'b0, 6, ph);
            wave(d, 8 - d, 6, ph);
            end_phase("sweep", ph);
            jitter = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of all cycle counters and measurement outputs (legal 4..32).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, number of input synchronizer flops (legal 2..4).
REQ-003 SHALL provide port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port: pwm_in  input  1  asynchronous PWM waveform to measure (e.g. looped-back LED drive).
REQ-006 SHALL provide port: high_cycles  output  CNT_W  last measured high time, in clk cycles.
REQ-007 SHALL provide port: period_cycles  output  CNT_W  last measured period, in clk cycles.
REQ-008 SHALL provide port: meas_valid  output  1  one-cycle pulse when high_cycles/period_cycles update.
REQ-009 SHALL provide port: timeout  output  1  one-cycle pulse when no rising edge is seen for 2^CNT_W-1 cycles.
REQ-010 SHALL provide port: level  output  1  synchronized pwm_in level (last synchronizer stage).

Function
REQ-011 pwm_in SHALL pass through SYNC_STAGES flops; rise/fall SHALL be detected by comparing the last stage with one additional registered copy.
REQ-012 Detection latency SHALL be SYNC_STAGES+1 cycles from pwm_in transition to internal rise/fall strobe; equal for both edges, so measurements are latency-free.
REQ-013 SHALL implement FSM with states IDLE, HIGH, LOW.
REQ-014 IDLE: waits for rise; fall ignored; on rise -> HIGH, period counter and high counter loaded with 1; no output update.
REQ-015 HIGH: both counters increment by 1 per cycle; on fall -> LOW, high counter value captured into internal hold register.
REQ-016 LOW: period counter increments; on rise -> HIGH, period_cycles <= period counter, high_cycles <= hold register, meas_valid pulses next cycle, both counters reload to 1.
REQ-017 A rise detected in HIGH (fall missed, impossible for clean synchronizer output) SHALL be treated as a LOW-state rise with hold = high counter.
REQ-018 period_cycles SHALL equal exact clk-cycle spacing between consecutive detected rises; high_cycles exact spacing from rise to following fall.
REQ-019 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-020 When period counter reaches 2^CNT_W-1 in HIGH or LOW: timeout pulses one cycle, FSM -> IDLE, high_cycles/period_cycles unchanged, meas_valid not asserted.
REQ-021 In IDLE, an internal idle counter SHALL also run; timeout SHALL pulse each time it reaches 2^CNT_W-1 (then reload 0), indicating constant 0%/100% duty; level gives the stuck value.
REQ-022 Rise on the same cycle counter saturates: rise takes priority; measurement published (period = 2^CNT_W-1), no timeout.
REQ-023 meas_valid and timeout SHALL never assert in the same cycle.
REQ-024 Minimum measurable: high >= 1, low >= 1, period >= 2 cycles.

Reset
REQ-025 On rst=1 at a clk edge: FSM -> IDLE; synchronizer flops, edge register, counters, hold register cleared to 0.
REQ-026 Reset values: high_cycles=0, period_cycles=0, meas_valid=0, timeout=0, level=0.
REQ-027 Reset mid-measurement SHALL discard partial counts; first meas_valid after release requires two detected rises.
REQ-028 A pwm_in already high at reset release SHALL not create a rise until it goes low then high.

Verification
REQ-029 pwm_in 3 high/5 low repeating, CNT_W=16 -> after 2nd rise, meas_valid pulses each 8 cycles, high_cycles=3, period_cycles=8.
REQ-030 pwm_in 1 high/1 low -> high_cycles=1, period_cycles=2 every 2 cycles; no timeout.
REQ-031 CNT_W=4, pwm_in held 0 after reset -> timeout pulses every 15 cycles, level=0, meas_valid never asserts.
REQ-032 CNT_W=4, steady 4/4 waveform then pwm_in stuck 1 -> timeout 15 cycles after last rise, outputs hold 4/8, FSM IDLE; waveform resumes -> first valid after second rise.
REQ-033 rst asserted mid-HIGH for 1 cycle during 3/5 waveform -> outputs 0 next cycle; next meas_valid reports 3/8 only after two full rises post-reset.
REQ-034 Duty sweep 1..7 of period 8 with pwm_in edges changed asynchronously (random phase vs clk) -> each meas_valid high_cycles within +/-1 of expected, period_cycles 8 +/-1, sum over consecutive windows exact.
